// File: rtl/tlb_mport.sv
// ============================================================================
// tlb_mport -- fully-associative joint TLB with NPORTS registered lookup
// ports, hardware Random/Wired management and a registered TLBP probe.
// Optional macro: TLB_WRITE_BYPASS_EN (forward write data into the compare).
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module tlb_mport #(
  parameter int NENTRIES = 32,
  parameter int NPORTS   = 2,
  parameter int IW       = $clog2(NENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    lk_valid,
  input  logic [NPORTS*32-1:0] lk_vaddr,
  input  logic [7:0]           asid,
  output logic [NPORTS-1:0]    rs_valid,
  output logic [NPORTS-1:0]    rs_hit,
  output logic [NPORTS*20-1:0] rs_pfn,
  output logic [NPORTS*3-1:0]  rs_c,
  output logic [NPORTS-1:0]    rs_d,
  output logic [NPORTS-1:0]    rs_v,
  output logic [NPORTS-1:0]    rs_stale,
  input  logic                 wr_en,
  input  logic                 wr_random,
  input  logic [IW-1:0]        wr_index,
  input  logic [77:0]          wr_entry,
  input  logic [IW-1:0]        rd_index,
  output logic [77:0]          rd_entry,
  input  logic                 wired_we,
  input  logic [IW-1:0]        wired_in,
  output logic [IW-1:0]        random,
  output logic [IW-1:0]        wired,
  input  logic                 pr_valid,
  input  logic [26:0]          pr_entryhi,
  output logic                 pr_done,
  output logic [IW:0]          pr_index
);

  localparam logic [IW-1:0] C_TOP = IW'(NENTRIES - 1);

  // Entry layout: vpn2[77:59] asid[58:51] g[50] pfn0[49:30] c0[29:27]
  // d0[26] v0[25] pfn1[24:5] c1[4:2] d1[1] v1[0]
  function automatic logic f_match(input logic [77:0] e,
                                   input logic [18:0] vpn2,
                                   input logic [7:0]  id);
    return (e[77:59] == vpn2) && (e[50] || (e[58:51] == id));
  endfunction

  logic [77:0]          ent_q [NENTRIES];
  logic [IW-1:0]        random_q, random_d;
  logic [IW-1:0]        wired_q;
  logic [IW-1:0]        wr_idx;

  logic [NPORTS-1:0]    rs_valid_q, rs_hit_q, rs_d_q, rs_v_q, rs_stale_q;
  logic [NPORTS*20-1:0] rs_pfn_q;
  logic [NPORTS*3-1:0]  rs_c_q;
  logic                 pr_done_q;
  logic [IW:0]          pr_index_q;

  logic [77:0]          cmp_ent [NENTRIES];
  logic [NPORTS-1:0]    lk_hit_d;
  logic [77:0]          lk_ent_d [NPORTS];
  logic                 pr_hit_d;
  logic [IW-1:0]        pr_idx_d;
  logic [NPORTS*12-1:0] unused_vaddr;

  assign wr_idx = wr_random ? random_q : wr_index;

  // Compare view of the array; with bypass the pending write is visible.
  always_comb begin
    for (int i = 0; i < NENTRIES; i++) begin
      cmp_ent[i] = ent_q[i];
`ifdef TLB_WRITE_BYPASS_EN
      if (wr_en && (wr_idx == IW'(i)))
        cmp_ent[i] = wr_entry;
`endif
    end
  end

  // Scan from the top so the lowest matching index is the one kept.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      lk_hit_d[p] = 1'b0;
      lk_ent_d[p] = '0;
      unused_vaddr[12*p +: 12] = lk_vaddr[32*p +: 12];
      for (int i = NENTRIES - 1; i >= 0; i--) begin
        if (f_match(cmp_ent[i], lk_vaddr[32*p+13 +: 19], asid)) begin
          lk_hit_d[p] = 1'b1;
          lk_ent_d[p] = cmp_ent[i];
        end
      end
    end
  end

  always_comb begin
    pr_hit_d = 1'b0;
    pr_idx_d = '0;
    for (int i = NENTRIES - 1; i >= 0; i--) begin
      if (f_match(cmp_ent[i], pr_entryhi[26:8], pr_entryhi[7:0])) begin
        pr_hit_d = 1'b1;
        pr_idx_d = IW'(i);
      end
    end
  end

  always_comb begin
    if (wired_we || (random_q == wired_q))
      random_d = C_TOP;
    else
      random_d = random_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENTRIES; i++)
        ent_q[i] <= '0;
      random_q <= C_TOP;
      wired_q  <= '0;
    end else begin
      if (wr_en)
        ent_q[wr_idx] <= wr_entry;
      random_q <= random_d;
      if (wired_we)
        wired_q <= wired_in;
    end
  end

  // Result registers; data fields hold while the port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_valid_q <= '0;
      rs_hit_q   <= '0;
      rs_pfn_q   <= '0;
      rs_c_q     <= '0;
      rs_d_q     <= '0;
      rs_v_q     <= '0;
      rs_stale_q <= '0;
      pr_done_q  <= 1'b0;
      pr_index_q <= '0;
    end else begin
      rs_valid_q <= lk_valid;
      for (int p = 0; p < NPORTS; p++) begin
        if (lk_valid[p]) begin
          rs_hit_q[p] <= lk_hit_d[p];
          if (lk_vaddr[32*p+12]) begin
            rs_pfn_q[20*p +: 20] <= lk_ent_d[p][24:5];
            rs_c_q[3*p +: 3]     <= lk_ent_d[p][4:2];
            rs_d_q[p]            <= lk_ent_d[p][1];
            rs_v_q[p]            <= lk_ent_d[p][0];
          end else begin
            rs_pfn_q[20*p +: 20] <= lk_ent_d[p][49:30];
            rs_c_q[3*p +: 3]     <= lk_ent_d[p][29:27];
            rs_d_q[p]            <= lk_ent_d[p][26];
            rs_v_q[p]            <= lk_ent_d[p][25];
          end
`ifdef TLB_WRITE_BYPASS_EN
          rs_stale_q[p] <= 1'b0;
`else
          rs_stale_q[p] <= wr_en;
`endif
        end
      end
      pr_done_q <= pr_valid;
      if (pr_valid)
        pr_index_q <= pr_hit_d ? {1'b0, pr_idx_d} : {1'b1, {IW{1'b0}}};
    end
  end

  assign rs_valid = rs_valid_q;
  assign rs_hit   = rs_hit_q;
  assign rs_pfn   = rs_pfn_q;
  assign rs_c     = rs_c_q;
  assign rs_d     = rs_d_q;
  assign rs_v     = rs_v_q;
  assign rs_stale = rs_stale_q;
  assign rd_entry = ent_q[rd_index];
  assign random   = random_q;
  assign wired    = wired_q;
  assign pr_done  = pr_done_q;
  assign pr_index = pr_index_q;

endmodule

`default_nettype wire

// File: tb/tb_tlb_mport.sv
// ============================================================================
// tb_tlb_mport -- directed self-checking bench for tlb_mport (32 entries,
// 2 ports). Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_tlb_mport;

  localparam int NENTRIES = 32;
  localparam int NPORTS   = 2;
  localparam int IW       = 5;

  logic                 clk;
  logic                 rst;
  logic [NPORTS-1:0]    lk_valid;
  logic [NPORTS*32-1:0] lk_vaddr;
  logic [7:0]           asid;
  logic [NPORTS-1:0]    rs_valid, rs_hit, rs_d, rs_v, rs_stale;
  logic [NPORTS*20-1:0] rs_pfn;
  logic [NPORTS*3-1:0]  rs_c;
  logic                 wr_en, wr_random;
  logic [IW-1:0]        wr_index, rd_index, wired_in, random, wired;
  logic [77:0]          wr_entry, rd_entry;
  logic                 wired_we, pr_valid, pr_done;
  logic [26:0]          pr_entryhi;
  logic [IW:0]          pr_index;

  int n_total = 0;
  int n_bad   = 0;

  tlb_mport #(.NENTRIES(NENTRIES), .NPORTS(NPORTS)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_vaddr(lk_vaddr), .asid(asid),
    .rs_valid(rs_valid), .rs_hit(rs_hit), .rs_pfn(rs_pfn), .rs_c(rs_c),
    .rs_d(rs_d), .rs_v(rs_v), .rs_stale(rs_stale),
    .wr_en(wr_en), .wr_random(wr_random), .wr_index(wr_index),
    .wr_entry(wr_entry), .rd_index(rd_index), .rd_entry(rd_entry),
    .wired_we(wired_we), .wired_in(wired_in), .random(random), .wired(wired),
    .pr_valid(pr_valid), .pr_entryhi(pr_entryhi), .pr_done(pr_done),
    .pr_index(pr_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [77:0] mk_ent(
      input logic [18:0] vpn2, input logic [7:0] id, input logic g,
      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
      input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, id, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  logic [77:0] e3, e8, e7;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; lk_valid = '0; lk_vaddr = '0; asid = '0;
    wr_en = 1'b0; wr_random = 1'b0; wr_index = '0; wr_entry = '0;
    rd_index = '0; wired_we = 1'b0; wired_in = '0;
    pr_valid = 1'b0; pr_entryhi = '0;
    tick(); tick();

    chk("rst_random", 96'(random), 96'd31);
    chk("rst_wired", 96'(wired), 96'd0);
    chk("rst_rs_valid", 96'(rs_valid), 96'd0);
    chk("rst_pr", 96'({pr_done, pr_index}), 96'd0);

    // Empty TLB: lookup misses on both ports
    rst = 1'b0;
    lk_valid = 2'b11; lk_vaddr = {32'h0040_1000, 32'h0040_1000};
    tick();
    lk_valid = 2'b00;
    chk("empty_valid", 96'(rs_valid), 96'h3);
    chk("empty_hit", 96'(rs_hit), 96'h0);
    tick(); tick(); tick(); tick();
    chk("random_dec5", 96'(random), 96'd26);

    // TLBWI entry 3, odd half valid
    e3 = mk_ent(19'h00200, 8'h05, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0,
                20'hABCDE, 3'd3, 1'b1, 1'b1);
    wr_en = 1'b1; wr_index = 5'd3; wr_entry = e3;
    tick();
    wr_en = 1'b0;
    asid = 8'h05; lk_valid = 2'b11;
    tick();
    chk("asid5_hit", 96'(rs_hit), 96'h3);
    chk("asid5_pfn", 96'(rs_pfn), 96'({20'hABCDE, 20'hABCDE}));
    chk("asid5_cdv", 96'({rs_c, rs_d, rs_v, rs_stale}), 96'({6'b011011, 2'b11, 2'b11, 2'b00}));
    asid = 8'h06;
    tick();
    chk("asid6_miss", 96'(rs_hit), 96'h0);
    chk("asid6_zero", 96'({rs_pfn, rs_c, rs_d, rs_v}), 96'h0);

    // Global bit set; port 1 hits the invalid even half
    e3[50] = 1'b1;
    lk_valid = 2'b00;
    wr_en = 1'b1; wr_index = 5'd3; wr_entry = e3;
    tick();
    wr_en = 1'b0;
    lk_valid = 2'b11; lk_vaddr = {32'h0040_0000, 32'h0040_1000};
    tick();
    lk_valid = 2'b00;
    chk("global_hit", 96'(rs_hit), 96'h3);
    chk("global_v", 96'(rs_v), 96'h1);
    chk("global_pfn", 96'(rs_pfn), 96'({20'h0, 20'hABCDE}));

    // Wired = 8, Random runs 31..8, TLBWR at 8 then wrap
    wired_we = 1'b1; wired_in = 5'd8;
    tick();
    wired_we = 1'b0;
    chk("wired_set_rand", 96'(random), 96'd31);
    chk("wired_val", 96'(wired), 96'd8);
    for (int k = 0; k < 23; k++) tick();
    chk("rand_at_wired", 96'(random), 96'd8);
    e8 = mk_ent(19'h00500, 8'h00, 1'b1, 20'h12345, 3'd2, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    wr_en = 1'b1; wr_random = 1'b1; wr_entry = e8;
    tick();
    wr_en = 1'b0; wr_random = 1'b0;
    chk("rand_wrap", 96'(random), 96'd31);
    rd_index = 5'd8; #1;
    chk("tlbwr_e8", 96'(rd_entry), 96'(e8));
    rd_index = 5'd3; #1;
    chk("tlbr_e3", 96'(rd_entry), 96'(e3));

    // TLBP hit and miss
    pr_valid = 1'b1; pr_entryhi = {19'h00200, 8'h05};
    tick();
    chk("probe_hit", 96'({pr_done, pr_index}), 96'({1'b1, 6'd3}));
    pr_entryhi = {19'h00300, 8'h05};
    tick();
    pr_valid = 1'b0;
    chk("probe_miss", 96'({pr_done, pr_index}), 96'({1'b1, 6'b100000}));
    tick();
    chk("probe_idle", 96'({pr_done, pr_index}), 96'({1'b0, 6'b100000}));

    // Write entry 7 and look it up in the same cycle; port 1 idle
    e7 = mk_ent(19'h00700, 8'h05, 1'b0, 20'h77777, 3'd2, 1'b0, 1'b1,
                20'h0, 3'd0, 1'b0, 1'b0);
    asid = 8'h05;
    wr_en = 1'b1; wr_index = 5'd7; wr_entry = e7;
    lk_valid = 2'b01; lk_vaddr = {32'h0040_0000, 32'h00E0_0000};
    tick();
    wr_en = 1'b0;
    chk("wrlk_valid", 96'(rs_valid), 96'h1);
`ifdef TLB_WRITE_BYPASS_EN
    chk("wrlk_hit", 96'(rs_hit), 96'h3);
    chk("wrlk_stale", 96'(rs_stale), 96'h0);
    chk("wrlk_pfn", 96'(rs_pfn), 96'({20'h0, 20'h77777}));
`else
    chk("wrlk_hit", 96'(rs_hit), 96'h2);
    chk("wrlk_stale", 96'(rs_stale), 96'h1);
    chk("wrlk_pfn", 96'(rs_pfn), 96'h0);
`endif
    tick();
    lk_valid = 2'b00;
    chk("replay_hit", 96'({rs_hit, rs_stale}), 96'({2'b11, 2'b00}));
    chk("replay_pfn_c", 96'({rs_pfn, rs_c}), 96'({20'h0, 20'h77777, 3'd0, 3'd2}));

    // Reset with a lookup and probe in flight
    lk_valid = 2'b11; pr_valid = 1'b1; rst = 1'b1;
    tick();
    lk_valid = 2'b00; pr_valid = 1'b0; rst = 1'b0;
    chk("midrst_out", 96'({rs_valid, pr_done, rs_hit}), 96'h0);
    chk("midrst_rw", 96'({random, wired}), 96'({5'd31, 5'd0}));
    rd_index = 5'd3; #1;
    chk("midrst_cleared", 96'(rd_entry), 96'h0);

    // Wired = 31 pins Random
    wired_we = 1'b1; wired_in = 5'd31;
    tick();
    wired_we = 1'b0;
    tick(); tick();
    chk("rand_pinned", 96'(random), 96'd31);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlb_mport.md
Name: tlb_mport

Overview:
- Next-generation fully-associative MIPS-style joint TLB with parametrised entry count and N independent lookup ports (fetch, load/store, spare).
- Registered lookup: 1-cycle latency. Adds hardware Random/Wired management for TLBWR, and a registered TLBP probe.
- Sits between the pipeline address-generation stages and the CP0 TLB instruction logic.

Parameters:
- NENTRIES, 32, number of TLB entries; power of two, 4..64. IW = $clog2(NENTRIES).
- NPORTS, 2, number of independent lookup ports, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lk_valid  in  NPORTS  per-port lookup request.
- lk_vaddr  in  NPORTS*32  virtual addresses; port p uses bits [32p+31:32p].
- asid  in  8  current ASID, shared by all ports.
- rs_valid  out  NPORTS  result valid, exactly 1 cycle after lk_valid.
- rs_hit  out  NPORTS  matching entry found.
- rs_pfn  out  NPORTS*20  selected PFN (odd/even half chosen by vaddr[12]).
- rs_c  out  NPORTS*3  cache attribute.
- rs_d  out  NPORTS  dirty bit.
- rs_v  out  NPORTS  valid bit.
- rs_stale  out  NPORTS  entries were written between issue and result.
- wr_en  in  1  write strobe (TLBWI/TLBWR).
- wr_random  in  1  1 = use the Random index (TLBWR), 0 = use wr_index (TLBWI).
- wr_index  in  IW  TLBWI index.
- wr_entry  in  78  {vpn2[18:0], asid[7:0], g, pfn0[19:0], c0[2:0], d0, v0, pfn1[19:0], c1[2:0], d1, v1}.
- rd_index  in  IW  TLBR index.
- rd_entry  out  78  combinational read of entry rd_index.
- wired_we  in  1  Wired write strobe.
- wired_in  in  IW  new Wired value.
- random  out  IW  current Random value.
- wired  out  IW  current Wired value.
- pr_valid  in  1  TLBP request.
- pr_entryhi  in  27  {vpn2[18:0], asid[7:0]}.
- pr_done  out  1  probe result valid, 1 cycle after pr_valid.
- pr_index  out  IW+1  MSB = P (miss), low IW bits = matching index.

Behaviour:
- Reset: all entries cleared to zero, so v0 = v1 = 0 and g = 0. Wired = 0; Random = NENTRIES-1. All rs_* = 0, pr_done = 0, pr_index = 0.
- Match rule: entry.vpn2 == vaddr[31:13] AND (entry.g OR entry.asid == asid).
  - Multiple matches are a software error; lowest index wins, deterministically.
  - Odd/even half is selected by vaddr[12].
- Lookup: stage 0 compares against the entry array and registers the result; stage 1 presents rs_*.
  - Every port is serviced every cycle; there is no backpressure.
  - rs_valid follows lk_valid by exactly 1 cycle.
  - When rs_valid = 0, the data outputs hold their last values.
  - Miss: rs_hit = 0 and pfn/c/d/v = 0.
- Write: entry array updates at the clock edge when wr_en = 1. Target index = random if wr_random = 1, else wr_index.
  - A write to an index below Wired via TLBWR is impossible, because Random >= Wired.
- Stale flag: rs_stale = 1 when wr_en was asserted in the same cycle as the lookup issue. The lookup used pre-write contents; the consumer must replay.
- Random: decrements by 1 every cycle. When Random == Wired, it next loads NENTRIES-1 (wrap-around).
  - wired_we: Wired <= wired_in and Random <= NENTRIES-1 on the same edge.
  - A TLBWR in the same cycle as wired_we uses the pre-update Random.
  - wired_in >= NENTRIES is impossible by width. wired_in = NENTRIES-1 pins Random at NENTRIES-1.
- Probe: same match rule, using pr_entryhi.asid. Result is registered.
  - pr_index = {0, idx} on hit; {1, 0} on miss.
  - A probe concurrent with wr_en sees pre-write contents.
- Reset mid-operation: in-flight rs_valid and pr_done are cleared on the next edge; no partial result is emitted.

Optional Feature:
- Macro: TLB_WRITE_BYPASS_EN.
- Defined: lookups and probes issued in a wr_en cycle compare against the post-write array (write data forwarded into the compare). rs_stale is tied to 0.
- Undefined: pre-write compare, with rs_stale as described in Behaviour.

Test Plan:
- Reset, then lookup 0x0040_1000 on all ports -> rs_valid 1 cycle later, rs_hit = 0. random = 31, and 5 cycles later random = 26.
- TLBWI idx 3 {vpn2 = 0x00200, asid = 0x05, g = 0, pfn1 = 0xABCDE, v1 = 1, d1 = 1, c1 = 3}. Lookup 0x0040_1000 with asid 5 -> hit, pfn 0xABCDE, c 3, d 1, v 1. Same lookup with asid 6 -> miss.
- Set g = 1 on the same entry, lookup with asid 6 -> hit. Lookup 0x0040_0000 -> hit, v = 0 (even half invalid).
- Write wired_in = 8 -> random = 31 next cycle, decrements to 8, then wraps to 31. A TLBWR at random = 8 writes entry 8.
- TLBP of {0x00200, 0x05} -> pr_index = 3. TLBP of {0x00300, 0x05} -> pr_index = {1, 0}. TLBR idx 3 returns the written entry.
- Write entry 7 and look it up in the same cycle:
  - Macro undefined -> miss, rs_stale = 1.
  - Macro defined -> hit, rs_stale = 0.
